key_schedule_ctrl: RTL and testbench

KEY_SCHEDULE_CTRL -- requirements
Module: key_schedule_ctrl

---
 rtl/key_schedule_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_key_schedule_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_schedule_ctrl.sv
// key_schedule_ctrl: sequencer around a DES-style key schedule round.
// The sequencer steps a 56-bit C/D state through 16 rounds and hands the
// 48-bit round keys to a valid/ready consumer.
//
// Ports:
//   clk      - single clock, rising edge
//   rst_n    - synchronous active-low reset (clears state and idx only)
//   req/ack  - start handshake; ack = req & idle, x and dec captured on ack
//   x        - 56-bit initial key state (post-PC1)
//   dec      - 1 = emit round keys 15..0, 0 = emit 0..15
//   k, k_idx, k_last, k_valid / k_ready - round key stream
//   busy     - high whenever a schedule is in progress
//
// Build option: define KEY_SCHEDULE_CTRL_DECRYPT_EN to add the 16x48 key
// buffer and the FILL/DRAIN reverse-order path. Without it dec is ignored
// and every request runs forward.
//
// States:
//   IDLE  | waiting for req; ack is combinational
//   GEN   | one round per transfer, key straight from the round logic
//   FILL  | reverse mode: 16 cycles computing keys into the buffer
//   DRAIN | reverse mode: buffered keys sent from idx 15 down to 0

// One key schedule round: rotate both 28-bit halves left (by one on rounds
// 0, 1, 8 and 15, by two otherwise) and select 48 bits through PC2.
module key_schedule (
  input  logic [55:0] x,
  input  logic [3:0]  i,
  output logic [55:0] r,
  output logic [47:0] k
);
  logic        one;
  logic [27:0] c;
  logic [27:0] d;

  always_comb begin
    one = (i == 4'd0) || (i == 4'd1) || (i == 4'd8) || (i == 4'd15);
    c   = one ? {x[54:28], x[55]} : {x[53:28], x[55:54]};
    d   = one ? {x[26:0], x[27]}  : {x[25:0], x[27:26]};
    r   = {c, d};
  end

  // PC2, bit n of the table (1 = MSB of r) maps to r[56-n]
  assign k = {r[42], r[39], r[45], r[32], r[55], r[51],
              r[53], r[28], r[41], r[50], r[35], r[46],
              r[33], r[37], r[44], r[52], r[30], r[48],
              r[40], r[49], r[29], r[36], r[43], r[54],
              r[15], r[4],  r[25], r[19], r[9],  r[1],
              r[26], r[16], r[5],  r[11], r[23], r[8],
              r[12], r[7],  r[17], r[0],  r[22], r[3],
              r[10], r[14], r[6],  r[20], r[27], r[24]};
endmodule

module key_schedule_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  output logic        ack,
  input  logic [55:0] x,
  input  logic        dec,
  output logic [47:0] k,
  output logic [3:0]  k_idx,
  output logic        k_last,
  output logic        k_valid,
  input  logic        k_ready,
  output logic        busy
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GEN   = 2'd1
`ifdef KEY_SCHEDULE_CTRL_DECRYPT_EN
    ,
    FILL  = 2'd2,
    DRAIN = 2'd3
`endif
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [55:0] s;
  logic [55:0] s_d;
  logic        s_we;
  logic [3:0]  idx;
  logic [3:0]  idx_nxt;
  logic [55:0] ks_r;
  logic [47:0] ks_k;

  key_schedule u_ks (
    .x (s),
    .i (idx),
    .r (ks_r),
    .k (ks_k)
  );

`ifdef KEY_SCHEDULE_CTRL_DECRYPT_EN
  logic [47:0] key_buf [16];
  logic        buf_we;

  always_ff @(posedge clk) begin
    if (buf_we) key_buf[idx] <= ks_k;
  end
`else
  logic unused_dec;
  assign unused_dec = dec;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= 4'd0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // s is intentionally left out of reset; it is always reloaded on ack
  always_ff @(posedge clk) begin
    if (s_we) s <= s_d;
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    s_we      = 1'b0;
    s_d       = ks_r;
`ifdef KEY_SCHEDULE_CTRL_DECRYPT_EN
    buf_we    = 1'b0;
`endif
    ack       = req && (state == IDLE);
    busy      = (state != IDLE);
    k_valid   = 1'b0;
    k_last    = 1'b0;
    k         = ks_k;
    k_idx     = idx;
    case (state)
      IDLE: begin
        if (ack) begin
          s_we      = 1'b1;
          s_d       = x;
          idx_nxt   = 4'd0;
          state_nxt = GEN;
`ifdef KEY_SCHEDULE_CTRL_DECRYPT_EN
          if (dec) state_nxt = FILL;
`endif
        end
      end
      GEN: begin
        k_valid = 1'b1;
        k_last  = (idx == 4'd15);
        if (k_ready) begin
          s_we = 1'b1;
          if (k_last) begin
            state_nxt = IDLE;
            idx_nxt   = 4'd0;
          end else begin
            idx_nxt = idx + 4'd1;
          end
        end
      end
`ifdef KEY_SCHEDULE_CTRL_DECRYPT_EN
      FILL: begin
        buf_we = 1'b1;
        s_we   = 1'b1;
        if (idx == 4'd15) begin
          state_nxt = DRAIN;
          idx_nxt   = 4'd15;
        end else begin
          idx_nxt = idx + 4'd1;
        end
      end
      DRAIN: begin
        k_valid = 1'b1;
        k       = key_buf[idx];
        k_last  = (idx == 4'd0);
        if (k_ready) begin
          if (k_last) begin
            state_nxt = IDLE;
            idx_nxt   = 4'd0;
          end else begin
            idx_nxt = idx - 4'd1;
          end
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_key_schedule_ctrl.sv
module tb_key_schedule_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic        ack;
  logic [55:0] x;
  logic        dec;
  logic [47:0] k;
  logic [3:0]  k_idx;
  logic        k_last;
  logic        k_valid;
  logic        k_ready;
  logic        busy;

  key_schedule_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .ack     (ack),
    .x       (x),
    .dec     (dec),
    .k       (k),
    .k_idx   (k_idx),
    .k_last  (k_last),
    .k_valid (k_valid),
    .k_ready (k_ready),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  localparam logic [55:0] KEY0 = 56'hF0CCAAF556678F;
  localparam logic [47:0] K_R0 = 48'h1B02EFFC7072;
  localparam logic [47:0] K_R15 = 48'hCB3D8B0E17F5;

  typedef struct packed {
    logic [47:0] k;
    logic [3:0]  idx;
    logic        last;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          rdy_mode = 0;
  int          cyc = 0;
  int          last_cyc = 0;
  logic [47:0] last_k = '0;
  logic        stalled = 1'b0;
  exp_t        held;

  function automatic void check(string name, logic [63:0] act, logic [63:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, want);
    end
  endfunction

  function automatic bit rev_mode(input logic d);
`ifdef KEY_SCHEDULE_CTRL_DECRYPT_EN
    return d;
`else
    return 1'b0;
`endif
  endfunction

  // Reference: textbook DES key schedule from the PC2 and shift tables.
  task automatic push_schedule(input logic [55:0] xin, input logic d);
    int pc2[48] = '{14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
                    23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
                    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    int shifts[16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    logic [27:0] c;
    logic [27:0] dd;
    logic [55:0] cd;
    logic [47:0] keys[16];
    exp_t e;
    c  = xin[55:28];
    dd = xin[27:0];
    for (int r = 0; r < 16; r++) begin
      for (int s = 0; s < shifts[r]; s++) begin
        c  = {c[26:0], c[27]};
        dd = {dd[26:0], dd[27]};
      end
      cd = {c, dd};
      for (int j = 0; j < 48; j++) keys[r][47-j] = cd[56-pc2[j]];
    end
    for (int n = 0; n < 16; n++) begin
      int r;
      r = rev_mode(d) ? 15 - n : n;
      e.k    = keys[r];
      e.idx  = r[3:0];
      e.last = (n == 15);
      exp_q.push_back(e);
    end
  endtask

  always @(posedge clk) cyc++;

  initial begin
    k_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: k_ready = 1'b1;
        1: k_ready = ~k_ready;
        default: k_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops the scoreboard on each transfer, checks stalls hold.
  always @(negedge clk) begin
    exp_t e;
    if (stalled) check("stall_hold", {k_valid, k, k_idx, k_last}, {1'b1, held});
    if (k_valid && !k_ready) begin
      stalled = 1'b1;
      held    = '{k, k_idx, k_last};
    end else begin
      stalled = 1'b0;
    end
    if (k_valid && k_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_xfer", {k, k_idx}, 64'h0);
      end else begin
        e = exp_q.pop_front();
        check("xfer", {k, k_idx, k_last}, e);
        if (k_last) begin
          last_k   = k;
          last_cyc = cyc;
        end
      end
    end
  end

  task automatic accept(output bit ok, output int acc);
    ok  = 1'b0;
    acc = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (ack) begin
        ok  = 1'b1;
        acc = cyc;
        return;
      end
    end
    check("ack_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) return;
    end
    check("idle_timeout", 0, 1);
    exp_q.delete();
  endtask

  task automatic run_sched(input logic [55:0] xin, input logic d, input int mode,
                           output logic [47:0] first_k);
    bit ok;
    int acc;
    int quiet;
    logic [63:0] t;
    first_k  = '0;
    rdy_mode = mode;
    push_schedule(xin, d);
    @(posedge clk);
    #1;
    x   = xin;
    dec = d;
    req = 1'b1;
    accept(ok, acc);
    @(posedge clk);
    #1;
    req = 1'b0;
    t   = {$urandom, $urandom};
    x   = t[55:0];
    dec = 1'($urandom_range(0, 1));
    if (!ok) begin
      exp_q.delete();
      return;
    end
    if (rev_mode(d)) begin
      quiet = 0;
      repeat (16) begin
        @(negedge clk);
        if (!k_valid) quiet++;
      end
      check("fill_quiet", quiet, 16);
      @(negedge clk);
      check("drain_first", {k_valid, k_idx}, {1'b1, 4'd15});
    end else begin
      @(negedge clk);
      check("gen_first", {k_valid, k_idx}, {1'b1, 4'd0});
    end
    first_k = k;
    wait_idle();
    if (mode == 0) check("last_latency", last_cyc - acc, rev_mode(d) ? 32 : 16);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    logic [47:0] f;
    logic [63:0] t;
    logic [55:0] x2;
    bit ok;
    int acc;
    int bad;
    bit second;
    int second_cyc;

    rst_n = 1'b0;
    req   = 1'b0;
    x     = '0;
    dec   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {k_valid, k_last, busy, ack}, 4'b0000);
    rst_n = 1'b1;

    // Known forward vector
    run_sched(KEY0, 1'b0, 0, f);
    check("fwd_k0", f, K_R0);
    check("fwd_k15", last_k, K_R15);

    // dec=1: reverse when the buffer is built in, forward otherwise
    run_sched(KEY0, 1'b1, 0, f);
    check("dec_first", f, rev_mode(1'b1) ? K_R15 : K_R0);
    check("dec_last", last_k, rev_mode(1'b1) ? K_R0 : K_R15);

    // Backpressure by toggling k_ready
    run_sched(KEY0, 1'b0, 1, f);
    check("bp_k0", f, K_R0);
    check("bp_k15", last_k, K_R15);

    // req held high during a schedule with a different x
    rdy_mode = 0;
    t  = {$urandom, $urandom};
    x2 = t[55:0];
    push_schedule(KEY0, 1'b0);
    push_schedule(x2, 1'b0);
    @(posedge clk);
    #1;
    x   = KEY0;
    dec = 1'b0;
    req = 1'b1;
    accept(ok, acc);
    @(posedge clk);
    #1;
    x = x2;
    bad = 0;
    second = 1'b0;
    second_cyc = 0;
    for (int n = 0; n < 60 && !second; n++) begin
      @(negedge clk);
      if (busy) begin
        if (ack) bad++;
      end else if (ack) begin
        second = 1'b1;
        second_cyc = cyc;
      end
    end
    check("busy_reject", bad, 0);
    check("second_accept", second, 1);
    check("reaccept_cycle", second_cyc - last_cyc, 1);
    @(posedge clk);
    #1;
    req = 1'b0;
    wait_idle();

    // Reset at k_idx=7 of a forward schedule
    rdy_mode = 0;
    t = {$urandom, $urandom};
    push_schedule(t[55:0], 1'b0);
    @(posedge clk);
    #1;
    x   = t[55:0];
    dec = 1'b0;
    req = 1'b1;
    accept(ok, acc);
    @(posedge clk);
    #1;
    req = 1'b0;
    ok  = 1'b0;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk);
      if (k_valid && k_idx == 4'd7) ok = 1'b1;
    end
    check("reach_idx7", ok, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_reset", {k_valid, busy, k_last}, 3'b000);
    exp_q.delete();
    rst_n = 1'b1;
    t = {$urandom, $urandom};
    run_sched(t[55:0], 1'b0, 0, f);

`ifdef KEY_SCHEDULE_CTRL_DECRYPT_EN
    // Reset partway through FILL
    t = {$urandom, $urandom};
    @(posedge clk);
    #1;
    x   = t[55:0];
    dec = 1'b1;
    req = 1'b1;
    accept(ok, acc);
    @(posedge clk);
    #1;
    req = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (k_valid || busy) bad++;
    end
    check("fill_reset_quiet", bad, 0);
`endif

    // Randomized schedules
    for (int n = 0; n < 6; n++) begin
      t = {$urandom, $urandom};
      run_sched(t[55:0], 1'($urandom_range(0, 1)), $urandom_range(0, 2), f);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
